// File: rtl/data_memory_pkg.sv
// Shared constants, word type and address range helper for the data memory.
package data_memory_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned IDX_W  = $clog2(DEPTH);

  typedef logic [DATA_W-1:0] dmem_word_t;

  localparam dmem_word_t DMEM_ZERO = '0;

  // Addresses at or beyond DEPTH are rejected outright; there is no wrap-around.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return (32'(addr) < DEPTH);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Storage array: synchronous full clear, single write port, asynchronous read port.
module dmem_array
  import data_memory_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  dmem_word_t       wdata,
  output dmem_word_t       rdata
);

  dmem_word_t mem [DEPTH];

  // Reset wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= DMEM_ZERO;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory for the MEM stage.
// Define DMEM_SYNC_READ_EN for a registered read port (one-cycle latency, read-before-write).
module data_memory
  import data_memory_pkg::*;
(
  output dmem_word_t        D_Data,
  input  logic [ADDR_W-1:0] A_DataAddress,
  input  dmem_word_t        D_WriteData,
  input  logic              C_DMRead,
  input  logic              C_DMWrite,
  input  logic              rst,
  input  logic              clk
);

  logic [IDX_W-1:0] idx;
  logic             addr_ok;
  dmem_word_t       arr_rdata;
  dmem_word_t       read_word;

  assign idx     = A_DataAddress[IDX_W-1:0];
  assign addr_ok = in_range(A_DataAddress);

  dmem_array u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (C_DMWrite & addr_ok),
    .addr  (idx),
    .wdata (D_WriteData),
    .rdata (arr_rdata)
  );

  // Read data is zero unless a valid, enabled read happens outside reset.
  assign read_word = (rst && C_DMRead && addr_ok) ? arr_rdata : DMEM_ZERO;

`ifdef DMEM_SYNC_READ_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      D_Data <= DMEM_ZERO;
    end else begin
      D_Data <= read_word;
    end
  end
`else
  assign D_Data = read_word;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed, table-driven bench for data_memory (combinational or DMEM_SYNC_READ_EN build).
module tb_data_memory;
  import data_memory_pkg::*;

  logic              clk;
  logic              rst;
  dmem_word_t        D_Data;
  logic [ADDR_W-1:0] A_DataAddress;
  dmem_word_t        D_WriteData;
  logic              C_DMRead;
  logic              C_DMWrite;

  int n_checks;
  int n_fail;

  typedef struct {
    string             name;
    logic [ADDR_W-1:0] addr;
    logic              rd;
    dmem_word_t        exp;
  } rd_vec_t;

  rd_vec_t vecs [9];

  data_memory dut (
    .D_Data        (D_Data),
    .A_DataAddress (A_DataAddress),
    .D_WriteData   (D_WriteData),
    .C_DMRead      (C_DMRead),
    .C_DMWrite     (C_DMWrite),
    .rst           (rst),
    .clk           (clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input dmem_word_t act, input dmem_word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 16'h%04h expected 16'h%04h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge.
  task automatic do_write(input logic [ADDR_W-1:0] addr, input dmem_word_t data);
    A_DataAddress = addr;
    D_WriteData   = data;
    C_DMRead      = 1'b0;
    C_DMWrite     = 1'b1;
    @(posedge clk);
    #1;
    C_DMWrite     = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [ADDR_W-1:0] addr,
                         input logic rd, input dmem_word_t exp);
    A_DataAddress = addr;
    C_DMRead      = rd;
    C_DMWrite     = 1'b0;
`ifdef DMEM_SYNC_READ_EN
    @(posedge clk);
`endif
    #1;
    check(name, D_Data, exp);
`ifndef DMEM_SYNC_READ_EN
    @(posedge clk);
    #1;
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{"rd_addr0_untouched", 16'h0000, 1'b1, 16'h0000};
    vecs[1] = '{"rd_addr1_written",   16'h0001, 1'b1, 16'h0014};
    vecs[2] = '{"rd_disabled_addr1",  16'h0001, 1'b0, 16'h0000};
    vecs[3] = '{"rd_addr255_top",     16'h00FF, 1'b1, 16'hA5A5};
    vecs[4] = '{"rd_oor_0100",        16'h0100, 1'b1, 16'h0000};
    vecs[5] = '{"rd_oor_ffff",        16'hFFFF, 1'b1, 16'h0000};
    vecs[6] = '{"rd_addr0_no_wrap",   16'h0000, 1'b1, 16'h0000};
    vecs[7] = '{"rd_addr2_empty",     16'h0002, 1'b1, 16'h0000};
    vecs[8] = '{"rd_addr254_empty",   16'h00FE, 1'b1, 16'h0000};

    rst           = 1'b0;
    A_DataAddress = '0;
    D_WriteData   = '0;
    C_DMRead      = 1'b1;
    C_DMWrite     = 1'b0;

    // Reset held for three edges; output must be zero while in reset.
    repeat (3) @(posedge clk);
    #1;
    check("rst_forces_zero", D_Data, 16'h0000);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) begin
      do_read($sformatf("post_reset_addr%0d", i), 16'(i), 1'b1, 16'h0000);
    end

    do_write(16'h0001, 16'd20);
    do_write(16'h00FF, 16'hA5A5);
    do_write(16'h0100, 16'hBEEF);
    do_write(16'hFFFF, 16'h1111);

    for (int i = 0; i < 9; i++) begin
      do_read(vecs[i].name, vecs[i].addr, vecs[i].rd, vecs[i].exp);
    end

    // Simultaneous read and write to the same address.
    A_DataAddress = 16'h0002;
    D_WriteData   = 16'd20;
    C_DMRead      = 1'b1;
    C_DMWrite     = 1'b1;
`ifdef DMEM_SYNC_READ_EN
    @(posedge clk);
    #1;
    C_DMWrite = 1'b0;
    check("rw_same_first_cycle", D_Data, 16'h0000);
    @(posedge clk);
    #1;
    check("rw_same_second_cycle", D_Data, 16'h0014);
`else
    #1;
    check("rw_same_before_edge", D_Data, 16'h0000);
    @(posedge clk);
    #1;
    C_DMWrite = 1'b0;
    check("rw_same_after_edge", D_Data, 16'h0014);
`endif

    // Reset arriving alongside a pending write.
    do_write(16'h0005, 16'h1234);
    do_read("rd_addr5_before_rst", 16'h0005, 1'b1, 16'h1234);
    A_DataAddress = 16'h0006;
    D_WriteData   = 16'h5555;
    C_DMWrite     = 1'b1;
    C_DMRead      = 1'b1;
    rst           = 1'b0;
    @(posedge clk);
    #1;
    check("rd_during_rst", D_Data, 16'h0000);
    C_DMWrite = 1'b0;
    rst       = 1'b1;
    do_read("rd_addr5_after_rst", 16'h0005, 1'b1, 16'h0000);
    do_read("rd_addr6_after_rst", 16'h0006, 1'b1, 16'h0000);
    do_read("rd_addr1_after_rst", 16'h0001, 1'b1, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
